// File: rtl/vgg_mem_pkg.sv
// Shared constants and types for the VGG on-chip memory masters.
// Both the read and write masters use the same 11-bit word address / 16-bit data interface.
package vgg_mem_pkg;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 16;

  localparam logic [1:0] BYTEENABLE_ALL = 2'b11;

  typedef enum logic {
    IDLE,
    RUN
  } wm_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO buffering PE results ahead of the Avalon write port.
// The head word is read combinationally from registered storage.
module sync_fifo #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W:0]    wr_ptr;
  logic [PTR_W:0]    rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  // The extra pointer bit separates the full and empty cases when the indices match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr[PTR_W-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= din;
  end

endmodule

// File: rtl/onchip_write_master_output.sv
// Avalon-MM write master draining PE result words into on-chip output memory,
// one write per word at incrementing addresses from a control-supplied base.
module onchip_write_master_output
  import vgg_mem_pkg::*;
#(
  parameter int ADDR_W     = vgg_mem_pkg::ADDR_W,
  parameter int DATA_W     = vgg_mem_pkg::DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] addr_write,
  output logic [DATA_W-1:0] data_write,
  output logic [1:0]        byteenable,
  output logic              write,
  output logic              chipselect,
  input  logic              wait_request,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  output logic              busy,
  output logic              done,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_valid,
  output logic              data_in_ready
);

  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  wm_state_t         state_q;
  wm_state_t         state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   accept_left;
  logic [ADDR_W:0]   write_left;
  logic              done_q;
  logic              done_d;
  logic              load;
  logic              run;
  logic              push;
  logic              complete;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_dout;

  sync_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .pop  (complete),
    .din  (data_in),
    .dout (fifo_dout),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign run           = (state_q == RUN);
  assign data_in_ready = run && !fifo_full && (accept_left != '0);
  assign push          = data_in_valid && data_in_ready;
  assign write         = run && !fifo_empty;
  assign chipselect    = write;
  assign complete      = write && !wait_request;
  assign addr_write    = addr_q;
  assign data_write    = fifo_dout;
  assign byteenable    = BYTEENABLE_ALL;
  assign busy          = run;
  assign done          = done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // A zero-word job completes immediately without ever leaving IDLE.
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_words != '0) begin
            state_d = RUN;
            load    = 1'b1;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (complete && (write_left == CNT_ONE)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      accept_left <= '0;
      write_left  <= '0;
    end else if (load) begin
      addr_q      <= base_addr;
      accept_left <= num_words;
      write_left  <= num_words;
    end else begin
      if (push) accept_left <= accept_left - CNT_ONE;
      if (complete) begin
        addr_q     <= addr_q + ADDR_ONE;
        write_left <= write_left - CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_onchip_write_master_output.sv
// Randomized self-checking bench for onchip_write_master_output against a
// word-level model: the i-th accepted PE word must be written to base+i.
module tb_onchip_write_master_output;

  localparam int AW    = 11;
  localparam int DW    = 16;
  localparam int DEPTH = 4;

  logic          clk;
  logic          rst_n;
  logic [AW-1:0] addr_write;
  logic [DW-1:0] data_write;
  logic [1:0]    byteenable;
  logic          write;
  logic          chipselect;
  logic          wait_request;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   num_words;
  logic          busy;
  logic          done;
  logic [DW-1:0] data_in;
  logic          data_in_valid;
  logic          data_in_ready;

  onchip_write_master_output #(
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .addr_write   (addr_write),
    .data_write   (data_write),
    .byteenable   (byteenable),
    .write        (write),
    .chipselect   (chipselect),
    .wait_request (wait_request),
    .start        (start),
    .base_addr    (base_addr),
    .num_words    (num_words),
    .busy         (busy),
    .done         (done),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Reference model: job progress in words accepted / words written.
  bit            m_busy     = 1'b0;
  bit            m_done_exp = 1'b0;
  bit            m_done_nxt;
  int            m_base     = 0;
  int            m_num      = 0;
  int            m_acc      = 0;
  int            m_wr       = 0;
  logic [DW-1:0] m_words[$];
  int            done_seen  = 0;
  bit            exp_write;
  bit            exp_ready;

  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("rst_write", {31'd0, write}, 32'd0);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
      checkOutput("rst_done", {31'd0, done}, 32'd0);
      checkOutput("rst_ready", {31'd0, data_in_ready}, 32'd0);
      checkOutput("rst_cs", {31'd0, chipselect}, 32'd0);
      m_busy     = 1'b0;
      m_done_exp = 1'b0;
      m_words.delete();
    end else begin
      exp_write = m_busy && (m_acc > m_wr);
      exp_ready = m_busy && ((m_acc - m_wr) < DEPTH) && (m_acc < m_num);
      checkOutput("busy", {31'd0, busy}, {31'd0, m_busy});
      checkOutput("done", {31'd0, done}, {31'd0, m_done_exp});
      checkOutput("write", {31'd0, write}, {31'd0, exp_write});
      checkOutput("chipselect", {31'd0, chipselect}, {31'd0, exp_write});
      checkOutput("byteenable", {30'd0, byteenable}, 32'd3);
      checkOutput("ready", {31'd0, data_in_ready}, {31'd0, exp_ready});
      if (exp_write) begin
        checkOutput("addr", {21'd0, addr_write}, (m_base + m_wr) % 2048);
        checkOutput("data", {16'd0, data_write}, {16'd0, m_words[m_wr]});
      end
      if (done) done_seen++;
      m_done_nxt = 1'b0;
      if (m_busy) begin
        if (data_in_valid && exp_ready) begin
          m_words.push_back(data_in);
          m_acc++;
        end
        if (exp_write && !wait_request) begin
          m_wr++;
          if (m_wr == m_num) begin
            m_busy     = 1'b0;
            m_done_nxt = 1'b1;
          end
        end
      end else if (start) begin
        if (num_words == 0) begin
          m_done_nxt = 1'b1;
        end else begin
          m_busy = 1'b1;
          m_base = int'(base_addr);
          m_num  = int'(num_words);
          m_acc  = 0;
          m_wr   = 0;
          m_words.delete();
        end
      end
      m_done_exp = m_done_nxt;
    end
  end

  task automatic idleInputs();
    start         = 1'b0;
    data_in_valid = 1'b0;
    wait_request  = 1'b0;
  endtask

  // stall_mode: 0 none, 1 random at stall_pct, 2 stall cycles 3..5 after start.
  task automatic applyStimulus(input int base, input int num, input int valid_pct,
                               input int stall_mode, input int stall_pct,
                               input bit mid_start, input int reset_at,
                               input logic [DW-1:0] first_word);
    int            cyc;
    int            budget;
    int            done_before;
    bit            took;
    bit            finished;
    logic [DW-1:0] word;
    budget      = 4 * num + 50;
    done_before = done_seen;
    word        = first_word;
    finished    = 1'b0;
    cyc         = 0;
    @(posedge clk); #1;
    start         = 1'b1;
    base_addr     = AW'(base);
    num_words     = (AW + 1)'(num);
    data_in_valid = 1'b0;
    data_in       = word;
    wait_request  = 1'b0;
    while (cyc < budget) begin
      @(negedge clk);
      took = data_in_valid && data_in_ready;
      if (done) begin
        finished = 1'b1;
        break;
      end
      @(posedge clk); #1;
      cyc++;
      if (took) word = word + 16'd1;
      start = mid_start && (cyc == 2);
      if (start) begin
        base_addr = 11'h555;
        num_words = 12'd7;
      end
      data_in_valid = (valid_pct >= 100) || ($urandom_range(99) < valid_pct);
      data_in       = word;
      case (stall_mode)
        1:       wait_request = ($urandom_range(99) < stall_pct);
        2:       wait_request = (cyc >= 3) && (cyc <= 5);
        default: wait_request = 1'b0;
      endcase
      if ((reset_at > 0) && (cyc == reset_at)) begin
        rst_n = 1'b0;
        idleInputs();
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("no_done_after_reset", done_seen - done_before, 0);
        return;
      end
    end
    if (!finished) checkOutput("job_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    idleInputs();
    repeat (3) @(posedge clk);
    #1;
    checkOutput("done_count", done_seen - done_before, 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    base_addr = '0;
    num_words = '0;
    data_in   = '0;
    idleInputs();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    applyStimulus(16'h010, 3, 100, 0, 0, 1'b0, 0, 16'hA001);
    applyStimulus(16'h010, 6, 100, 2, 0, 1'b0, 0, 16'hA001);
    applyStimulus(16'h7FE, 4, 100, 0, 0, 1'b0, 0, 16'hB000);
    applyStimulus(16'h123, 0, 100, 0, 0, 1'b0, 0, 16'hC000);
    applyStimulus(16'h040, 2, 100, 0, 0, 1'b1, 0, 16'hD000);
    applyStimulus(16'h100, 4, 100, 0, 0, 1'b0, 3, 16'hE000);
    applyStimulus(16'h200, 1, 100, 0, 0, 1'b0, 0, 16'hF00D);

    for (int j = 0; j < 25; j++) begin
      applyStimulus(int'($urandom_range(2047)), int'($urandom_range(12)),
                    int'($urandom_range(100, 30)), 1, int'($urandom_range(60)),
                    1'b0, 0, DW'($urandom));
    end
    applyStimulus(16'h7F0, 2048, 80, 1, 20, 1'b0, 0, 16'h1234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
